// File: rtl/lut3_rr_sched_if.sv
// lut3_rr_sched_if
//   Handshake bundle between two minterm requesters, the shared truth-table
//   scheduler and the response consumer.
//   Signals:
//     req0_val/req1_val   requester n presents a minterm
//     req0_rdy/req1_rdy   requester n's minterm is accepted this cycle
//     req0_abc/req1_abc   minterm {a,b,c}, a is the MSB
//     resp_val            response slot holds a valid result
//     resp_rdy            consumer accepts the response
//     resp_f              evaluated truth-table value
//     resp_id             requester that produced resp_f
//     cfg_val/cfg_table   table write strobe / new table (LUT3_SCHED_PROG_EN only)
//   Modports: slave = scheduler view, master = requesters + consumer view.
interface lut3_rr_sched_if;
  logic       req0_val;
  logic       req0_rdy;
  logic [2:0] req0_abc;
  logic       req1_val;
  logic       req1_rdy;
  logic [2:0] req1_abc;
  logic       resp_val;
  logic       resp_rdy;
  logic       resp_f;
  logic       resp_id;
`ifdef LUT3_SCHED_PROG_EN
  logic       cfg_val;
  logic [7:0] cfg_table;
`endif

  modport slave (
    input  req0_val, req0_abc, req1_val, req1_abc, resp_rdy,
    output req0_rdy, req1_rdy, resp_val, resp_f, resp_id
`ifdef LUT3_SCHED_PROG_EN
    , input cfg_val, cfg_table
`endif
  );

  modport master (
    output req0_val, req0_abc, req1_val, req1_abc, resp_rdy,
    input  req0_rdy, req1_rdy, resp_val, resp_f, resp_id
`ifdef LUT3_SCHED_PROG_EN
    , output cfg_val, cfg_table
`endif
  );
endinterface

// File: rtl/lut3_rr_sched.sv
// lut3_rr_sched
//   Shares one 3-input truth-table unit between two requesters. Accepted
//   minterms are evaluated into a one-entry registered response slot
//   (EMPTY/FULL). Contention is resolved round-robin on the last grant.
//   Ports:
//     clk    sole clock, rising edge
//     reset  synchronous, active-high
//     bus    lut3_rr_sched_if.slave (request, response and optional cfg)
//   Optional feature: define LUT3_SCHED_PROG_EN to make the table writable
//   through cfg_val/cfg_table; otherwise the table is the constant 8'h97.
module lut3_rr_sched (
  input  logic              clk,
  input  logic              reset,
  lut3_rr_sched_if.slave    bus
);

  localparam logic [7:0] LUT_INIT = 8'h97;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t     state;
  logic       last_grant;   // index of the requester granted most recently
  logic       resp_f_q;
  logic       resp_id_q;
  logic [7:0] lut_q;

  logic       slot_open;
  logic       grant1;
  logic       accept;
  logic [2:0] abc_sel;

`ifndef LUT3_SCHED_PROG_EN
  assign lut_q = LUT_INIT;
`endif

  always_comb begin
    slot_open = (state == EMPTY) || bus.resp_rdy;
    // Contended cycles go to whoever did not win last time.
    if (bus.req0_val && bus.req1_val) grant1 = ~last_grant;
    else                              grant1 = bus.req1_val;
    accept  = !reset && slot_open && (bus.req0_val || bus.req1_val);
    abc_sel = grant1 ? bus.req1_abc : bus.req0_abc;
  end

  assign bus.req0_rdy = accept && !grant1;
  assign bus.req1_rdy = accept &&  grant1;
  assign bus.resp_val = (state == FULL);
  assign bus.resp_f   = resp_f_q;
  assign bus.resp_id  = resp_id_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      resp_f_q   <= 1'b0;
      resp_id_q  <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state      <= FULL;
            resp_f_q   <= lut_q[abc_sel];
            resp_id_q  <= grant1;
            last_grant <= grant1;
          end
        end
        FULL: begin
          if (accept) begin
            resp_f_q   <= lut_q[abc_sel];
            resp_id_q  <= grant1;
            last_grant <= grant1;
          end else if (bus.resp_rdy) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef LUT3_SCHED_PROG_EN
  // Same-edge evaluation above reads the pre-write table.
  always_ff @(posedge clk) begin
    if (reset)            lut_q <= LUT_INIT;
    else if (bus.cfg_val) lut_q <= bus.cfg_table;
  end
`endif

endmodule

// File: doc/lut3_rr_sched.md
LUT3_RR_SCHED -- requirements
Module: lut3_rr_sched

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports req0_val/req1_val, input, 1 each, requester n presents a minterm.
REQ-004 SHALL have ports req0_rdy/req1_rdy, output, 1 each, requester n's minterm is accepted this cycle.
REQ-005 SHALL have ports req0_abc/req1_abc, input, 3 each, minterm {a,b,c} with a as the MSB.
REQ-006 SHALL have port resp_val, output, 1, response slot holds a valid result.
REQ-007 SHALL have port resp_rdy, input, 1, consumer accepts the response.
REQ-008 SHALL have port resp_f, output, 1, evaluated truth-table value.
REQ-009 SHALL have port resp_id, output, 1, index of the requester that produced resp_f.
REQ-010 SHALL have ports cfg_val (input, 1, table write strobe) and cfg_table (input, 8, new table; bit i is f for {a,b,c}=i), present only under REQ-030.

Function
REQ-011 SHALL share one 3-input truth-table unit between two requesters via a one-entry registered response slot.
REQ-012 Slot FSM SHALL have states EMPTY and FULL; resp_val SHALL equal (state==FULL).
REQ-013 Slot SHALL be able to accept a request ("open") when EMPTY, or when FULL with resp_rdy=1 in the same cycle.
REQ-014 Grant: only req0_val -> req0; only req1_val -> req1; both -> the requester not granted last; none -> no grant.
REQ-015 reqN_rdy SHALL be 1 only when the slot is open and N is granted (combinational on val, resp_rdy, state, pointer); at most one rdy high per cycle.
REQ-016 Last-grant pointer SHALL update only on an accepted request; it SHALL not change while stalled.
REQ-017 On acceptance at edge N, the slot SHALL load resp_f=table[abc] and resp_id=granted index; resp_val SHALL be 1 from cycle N+1 (one-cycle latency).
REQ-018 Transitions: EMPTY+accept->FULL; FULL+resp_rdy+accept->FULL with new data (full throughput); FULL+resp_rdy+no accept->EMPTY; FULL+!resp_rdy->FULL with resp_f/resp_id held stable.
REQ-019 resp_rdy while EMPTY SHALL be ignored.
REQ-020 The truth table SHALL be an 8-bit register; evaluation SHALL index it with {a,b,c}.

Reset
REQ-021 reset SHALL force state EMPTY, resp_val=0, resp_f=0, resp_id=0.
REQ-022 reset SHALL set the last-grant pointer to 1 so that req0 wins the first contended cycle.
REQ-023 reset SHALL load the table with 8'h97 (f=1 for minterms 0,1,2,4,7; f=0 for 3,5,6).
REQ-024 reqN_rdy SHALL be 0 during any cycle where reset=1.
REQ-025 Reset asserted while FULL SHALL discard the pending response without a handshake.
REQ-026 reset SHALL take priority over cfg_val and over all accepts in the same cycle.

Configuration
REQ-030 With LUT3_SCHED_PROG_EN defined, cfg_val/cfg_table SHALL exist; cfg_val=1 SHALL load cfg_table into the table at the edge, regardless of slot state.
REQ-031 A request accepted in the same cycle as a cfg write SHALL be evaluated with the old table; requests accepted later SHALL use the new one.
REQ-032 A response already in the slot SHALL not change due to a cfg write.
REQ-033 Without LUT3_SCHED_PROG_EN, the cfg ports SHALL be absent and the table SHALL be constant 8'h97.

Verification
REQ-040 Reset, then req0_val=1 with abc=3'b011, resp_rdy=1 -> req0_rdy=1 at cycle 0; cycle 1 resp_val=1, resp_f=0, resp_id=0; sweep all 8 minterms to match 8'h97.
REQ-041 Both val high for 4 cycles, resp_rdy=1, abc0=3'b000, abc1=3'b101 -> resp_id sequence 0,1,0,1 and resp_f sequence 1,0,1,0.
REQ-042 FULL with resp_rdy=0 for 3 cycles, both reqs valid -> req0_rdy=req1_rdy=0; resp_f/resp_id stable; pointer unchanged; on resp_rdy=1, the non-last requester is accepted in that same cycle.
REQ-043 Back-to-back req1 only, resp_rdy=1, abc 3'b111 then 3'b110 -> resp_val=1 on consecutive cycles, resp_f=1 then 0, resp_id=1 both times.
REQ-044 Reset asserted for one cycle while FULL -> next cycle resp_val=0 and resp_id=0; the first subsequent contended cycle grants req0.
REQ-045 (LUT3_SCHED_PROG_EN) cfg_val=1 with cfg_table=8'h08 in the same cycle req0 is accepted with abc=3'b011 -> resp_f=0 (old table); the next accepted abc=3'b011 -> resp_f=1.
